// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and sequencer in front of the single-ported dmem
module dmem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int MAX_RUN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic             dmem_sel,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata
);

  localparam logic [WIDTH-1:0] LAST_WORD = WIDTH'(MEM_DEPTH - 4);
  localparam logic [3:0]       RUN_LIMIT = 4'(MAX_RUN);

  logic             c_win;
  logic             sel_we;
  logic             acc_err;
  logic [WIDTH-1:0] resp_data;

  logic [3:0]       run_cnt_q, run_cnt_d;
  logic             c_rvalid_q, c_rvalid_d;
  logic             d_rvalid_q, d_rvalid_d;
  logic             c_err_q, c_err_d;
  logic             d_err_q, d_err_d;
  logic [WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Port C wins every contended cycle until it has run MAX_RUN times in a row.
  always_comb begin
    c_win      = c_req && (!d_req || (run_cnt_q != RUN_LIMIT));
    c_gnt      = rst_n && c_win;
    d_gnt      = rst_n && d_req && !c_win;
    sel_we     = d_gnt ? d_we    : c_we;
    dmem_addr  = d_gnt ? d_addr  : c_addr;
    dmem_wdata = d_gnt ? d_wdata : c_wdata;
    acc_err    = (dmem_addr[1:0] != 2'b00) || (dmem_addr > LAST_WORD);
    dmem_sel   = (c_gnt || d_gnt) && sel_we && !acc_err;
    resp_data  = (sel_we || acc_err) ? '0 : dmem_rdata;
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!d_req || d_gnt) begin
      run_cnt_d = 4'd0;
    end else if (c_gnt && (run_cnt_q != RUN_LIMIT)) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
  end

  always_comb begin
    c_rvalid_d = c_gnt;
    d_rvalid_d = d_gnt;
    c_err_d    = c_gnt && acc_err;
    d_err_d    = d_gnt && acc_err;
    c_rdata_d  = c_gnt ? resp_data : c_rdata_q;
    d_rdata_d  = d_gnt ? resp_data : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q  <= 4'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_err_q    <= c_err_d;
      d_err_q    <= d_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_err    = c_err_q;
  assign d_err    = d_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        dmem_sel;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t cq[$];
  resp_t dq[$];
  int    total = 0;
  int    bad   = 0;
  int    cycn  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycn++;

  dmem_arbiter #(.WIDTH(32), .MEM_DEPTH(1024), .MAX_RUN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .dmem_sel(dmem_sel), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  assign dmem_rdata = mem[dmem_addr[9:2]];
  always @(posedge clk) if (dmem_sel) mem[dmem_addr[9:2]] <= dmem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic  ev;
    resp_t r;
    ev = (cq.size() > 0) && (cq[0].due == cycn);
    chk("c_rvalid", {31'b0, c_rvalid}, {31'b0, ev});
    if (ev) begin
      r = cq.pop_front();
      chk("c_err", {31'b0, c_err}, {31'b0, r.err});
      chk("c_rdata", c_rdata, r.rdata);
    end
    ev = (dq.size() > 0) && (dq[0].due == cycn);
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, ev});
    if (ev) begin
      r = dq.pop_front();
      chk("d_err", {31'b0, d_err}, {31'b0, r.err});
      chk("d_rdata", d_rdata, r.rdata);
    end
  end

  // One bus cycle: drive at posedge+1, check grants at negedge, queue responses.
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic egc, input logic egd, input logic eec, input logic eed,
                     input logic [31:0] erc, input logic [31:0] erd);
    logic esel;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
    esel = (egc && cw && !eec) || (egd && dw && !eed);
    chk("c_gnt", {31'b0, c_gnt}, {31'b0, egc});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, egd});
    chk("dmem_sel", {31'b0, dmem_sel}, {31'b0, esel});
    chk("dmem_addr", dmem_addr, egd ? da : ca);
    if (egc) cq.push_back('{due: cycn + 1, err: eec, rdata: erc});
    if (egd) dq.push_back('{due: cycn + 1, err: eed, rdata: erd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h8; c_wdata = 32'h1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c_gnt", {31'b0, c_gnt}, 32'h0);
    chk("rst d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst dmem_sel", {31'b0, dmem_sel}, 32'h0);
    chk("rst c_rdata", c_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    chk("rst c_err", {31'b0, c_err}, 32'h0);
    chk("rst d_err", {31'b0, d_err}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic write/read on each port
    cyc(1, 1, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h8, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    cyc(0, 0, 0, 0, 1, 1, 32'h4, 32'hAAAAAAAA, 0, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h4, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hAAAAAAAA, 32'h0);

    // misaligned and out-of-range rejects
    cyc(1, 1, 32'h6, 32'h55555555, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h4, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hAAAAAAAA, 32'h0);
    cyc(0, 0, 0, 0, 1, 1, 32'h400, 32'h77777777, 0, 1, 0, 1, 32'h0, 32'h0);
    cyc(1, 0, 32'h3FC, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h100000FF, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 32'h402, 32'h0, 0, 1, 0, 1, 32'h0, 32'h0);

    // contention: CCCCD repeating
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 32'h100, 32'h0C0C0C0C, 1, 1, 32'h104, 32'h0D0D0D0D,
          (i % 5) != 4, (i % 5) == 4, 0, 0, 32'h0, 32'h0);
    end
    cyc(0, 0, 0, 0, 1, 0, 32'h104, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0D0D0D0D);
    cyc(1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0C0C0C0C, 32'h0);

    // read-after-write back to back
    cyc(1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h12345678, 32'h0);

    // reset during a granted C read
    cyc(1, 1, 32'h20, 32'h0000CAFE, 1, 1, 32'h24, 32'h0000BEEF, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h8, 32'h0, 1, 1, 32'h24, 32'h0000BEEF, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h4;
    @(negedge clk);
    chk("run_cnt before reset", {28'b0, dut.run_cnt_q}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst c_rvalid", {31'b0, c_rvalid}, 32'h0);
    chk("mid-rst c_rdata", c_rdata, 32'h0);
    chk("mid-rst run_cnt", {28'b0, dut.run_cnt_q}, 32'h0);
    chk("mid-rst c_gnt", {31'b0, c_gnt}, 32'h0);
    chk("mid-rst dmem_sel", {31'b0, dmem_sel}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 32'h8, 32'h0, 1, 0, 32'h24, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 32'h20, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0000CAFE);
    idle();
    idle();

    chk("c queue drained", cq.size(), 32'h0);
    chk("d queue drained", dq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
